// File: rtl/alu_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_reg_bank_if
// Description : Button, control and result bundle of the ALU register bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_reg_bank_if #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    parameter int SELW  = $clog2(NREG + 1)
);
    logic [NREG-1:0]       btn;
    logic [NREG-1:0]       dir;
    logic                  load;
    logic [SELW-1:0]       src_sel;
    logic [SELW-1:0]       a_sel;
    logic [SELW-1:0]       b_sel;
    logic [1:0]            alu_op;
    logic                  res_btn;
    logic [NREG*WIDTH-1:0] regs_q;
    logic [WIDTH-1:0]      result_q;
    logic [WIDTH-1:0]      alu_y;
    logic [2:0]            flags_q;
    logic [NREG:0]         strobe_q;

    modport master (
        output btn, dir, load, src_sel, a_sel, b_sel, alu_op, res_btn,
        input  regs_q, result_q, alu_y, flags_q, strobe_q
    );

    modport slave (
        input  btn, dir, load, src_sel, a_sel, b_sel, alu_op, res_btn,
        output regs_q, result_q, alu_y, flags_q, strobe_q
    );
endinterface
`default_nettype wire

// File: rtl/alu_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : alu_reg_bank
// Description : Button-stepped operand registers with a registered ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_reg_bank #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    parameter int SAT   = 0,
    parameter int SELW  = $clog2(NREG + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_reg_bank_if.slave  bus
);

    logic [NREG:0]         r_s1, r_s2, r_s3, r_strobe;
    logic [NREG:0]         w_strobe;
    logic [NREG*WIDTH-1:0] r_regs, w_regs_nxt;
    logic [WIDTH-1:0]      r_result;
    logic [2:0]            r_flags;
    logic [WIDTH-1:0]      w_a, w_b, w_src, w_alu_y;
    logic [WIDTH:0]        w_sum, w_dif;
    logic                  w_c, w_v, w_z;

    // Codes 0..NREG-1 pick a register, NREG picks the result, anything else is 0
    function automatic logic [WIDTH-1:0] f_pick(
        input logic [SELW-1:0]       sel,
        input logic [NREG*WIDTH-1:0] regs,
        input logic [WIDTH-1:0]      res
    );
        f_pick = '0;
        for (int i = 0; i < NREG; i++)
            if (sel == SELW'(i)) f_pick = regs[i*WIDTH +: WIDTH];
        if (sel == SELW'(NREG)) f_pick = res;
    endfunction

    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cur, input logic dn);
        if (dn) f_step = (SAT != 0 && cur == '0) ? cur : cur - WIDTH'(1);
        else    f_step = (SAT != 0 && cur == '1) ? cur : cur + WIDTH'(1);
    endfunction

    assign w_strobe = r_s2 & ~r_s3;
    assign w_a      = f_pick(bus.a_sel,   r_regs, r_result);
    assign w_b      = f_pick(bus.b_sel,   r_regs, r_result);
    assign w_src    = f_pick(bus.src_sel, r_regs, r_result);
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_dif    = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_alu_y = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        case (bus.alu_op)
            2'b00: begin
                w_alu_y = w_sum[WIDTH-1:0];
                w_c     = w_sum[WIDTH];
                w_v     = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            2'b01: begin
                w_alu_y = w_dif[WIDTH-1:0];
                w_c     = w_dif[WIDTH];
                w_v     = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_dif[WIDTH-1] != w_a[WIDTH-1]);
            end
            2'b10:   w_alu_y = w_a & w_b;
            default: w_alu_y = w_a ^ w_b;
        endcase
        w_z = (w_alu_y == '0);
    end

    // All committing registers see pre-edge values, so simultaneous strobes never forward
    always_comb begin
        w_regs_nxt = r_regs;
        for (int i = 0; i < NREG; i++)
            if (w_strobe[i])
                w_regs_nxt[i*WIDTH +: WIDTH] = bus.load ? w_src
                                             : f_step(r_regs[i*WIDTH +: WIDTH], bus.dir[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_s3     <= '0;
            r_strobe <= '0;
            r_regs   <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_s1     <= {bus.res_btn, bus.btn};
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_strobe <= w_strobe;
            r_regs   <= w_regs_nxt;
            if (w_strobe[NREG]) begin
                r_result <= w_alu_y;
                r_flags  <= {w_v, w_c, w_z};
            end
        end
    end

    assign bus.regs_q   = r_regs;
    assign bus.result_q = r_result;
    assign bus.alu_y    = w_alu_y;
    assign bus.flags_q  = r_flags;
    assign bus.strobe_q = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_alu_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_reg_bank
// Description : Directed bench for alu_reg_bank, wrap and saturate builds side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_reg_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    alu_reg_bank_if #(.WIDTH(4), .NREG(4)) bus ();
    alu_reg_bank_if #(.WIDTH(4), .NREG(4)) bus_s ();

    alu_reg_bank #(.WIDTH(4), .NREG(4), .SAT(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    alu_reg_bank #(.WIDTH(4), .NREG(4), .SAT(1)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rg(input logic [15:0] q, input int i);
        return q[i*4 +: 4];
    endfunction

    task automatic set_ctl(input logic [3:0] dir, input logic ld, input logic [2:0] src,
                           input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
        bus.dir   = dir;  bus.load   = ld; bus.src_sel   = src;
        bus.a_sel = a;    bus.b_sel  = b;  bus.alu_op    = op;
        bus_s.dir   = dir;  bus_s.load  = ld; bus_s.src_sel = src;
        bus_s.a_sel = a;    bus_s.b_sel = b;  bus_s.alu_op  = op;
    endtask

    task automatic set_btn(input logic [4:0] v);
        bus.btn   = v[3:0];  bus.res_btn   = v[4];
        bus_s.btn = v[3:0];  bus_s.res_btn = v[4];
    endtask

    // High for one cycle, then park at the negedge right after the commit edge
    task automatic press(input logic [4:0] m);
        set_btn(m);
        @(negedge clk);
        set_btn(5'b0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        set_ctl(4'b0000, 1'b0, 3'd0, 3'd0, 3'd1, 2'b00);
        set_btn(5'b0);
        repeat (3) @(negedge clk);
        check("rst_regs",   32'(bus.regs_q),   32'h0);
        check("rst_result", 32'(bus.result_q), 32'h0);
        check("rst_flags",  32'(bus.flags_q),  32'h0);
        check("rst_strobe", 32'(bus.strobe_q), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Decrement from 0: wraps to F, holds at 0 when saturating
        set_ctl(4'b0001, 1'b0, 3'd0, 3'd0, 3'd1, 2'b00);
        set_btn(5'b00001);
        @(negedge clk);
        set_btn(5'b0);
        @(negedge clk);
        check("stb_early", 32'(bus.strobe_q), 32'h0);
        @(negedge clk);
        check("dec_wrap",  32'(rg(bus.regs_q, 0)), 32'hF);
        check("stb_pulse", 32'(bus.strobe_q), 32'h01);
        check("sat_dec_hold", 32'(rg(bus_s.regs_q, 0)), 32'h0);
        @(negedge clk);
        check("stb_clear", 32'(bus.strobe_q), 32'h0);
        press(5'b00001);
        check("dec_again", 32'(rg(bus.regs_q, 0)), 32'hE);

        for (int k = 0; k < 15; k++) press(5'b00010);
        check("inc_to_max", 32'(rg(bus.regs_q, 1)), 32'hF);
        check("sat_inc_to_max", 32'(rg(bus_s.regs_q, 1)), 32'hF);
        press(5'b00010);
        check("inc_wrap", 32'(rg(bus.regs_q, 1)), 32'h0);
        check("sat_inc_hold", 32'(rg(bus_s.regs_q, 1)), 32'hF);

        // reg0 E->7, reg1 0->1
        for (int k = 0; k < 7; k++) press(5'b00001);
        press(5'b00010);
        check("reg0_seven", 32'(rg(bus.regs_q, 0)), 32'h7);
        #1;
        check("alu_preview", 32'(bus.alu_y), 32'h8);
        press(5'b10000);
        check("add_res",     32'(bus.result_q), 32'h8);
        check("add_flags",   32'(bus.flags_q),  32'h4);
        check("res_strobe",  32'(bus.strobe_q), 32'h10);
        check("sat_add_res", 32'(bus_s.result_q), 32'hF);
        check("sat_add_flags", 32'(bus_s.flags_q), 32'h0);

        // reg0 7->1, reg1 1->2, then 1-2
        for (int k = 0; k < 6; k++) press(5'b00001);
        press(5'b00010);
        set_ctl(4'b0001, 1'b0, 3'd0, 3'd0, 3'd1, 2'b01);
        press(5'b10000);
        check("sub_res",   32'(bus.result_q), 32'hF);
        check("sub_flags", 32'(bus.flags_q),  32'h2);
        check("sat_sub_res",   32'(bus_s.result_q), 32'h1);
        check("sat_sub_flags", 32'(bus_s.flags_q),  32'h2);

        set_ctl(4'b0001, 1'b1, 3'd4, 3'd0, 3'd1, 2'b01);
        press(5'b01000);
        check("load_result", 32'(rg(bus.regs_q, 3)), 32'hF);
        set_ctl(4'b0001, 1'b1, 3'd7, 3'd0, 3'd1, 2'b01);
        press(5'b01000);
        check("load_invalid", 32'(rg(bus.regs_q, 3)), 32'h0);

        // reg0 1->5, reg2 <= reg0, then 5^5
        set_ctl(4'b0000, 1'b0, 3'd0, 3'd0, 3'd2, 2'b11);
        for (int k = 0; k < 4; k++) press(5'b00001);
        set_ctl(4'b0000, 1'b1, 3'd0, 3'd0, 3'd2, 2'b11);
        press(5'b00100);
        check("load_reg", 32'(rg(bus.regs_q, 2)), 32'h5);
        set_ctl(4'b0000, 1'b0, 3'd0, 3'd0, 3'd2, 2'b11);
        press(5'b10000);
        check("xor_res",   32'(bus.result_q), 32'h0);
        check("xor_flags", 32'(bus.flags_q),  32'h1);

        // reg1 <= reg2 (5), reg0 5->3, then load and commit on one edge
        set_ctl(4'b0001, 1'b1, 3'd2, 3'd0, 3'd1, 2'b00);
        press(5'b00010);
        set_ctl(4'b0001, 1'b0, 3'd2, 3'd0, 3'd1, 2'b00);
        press(5'b00001);
        press(5'b00001);
        check("pre_sim_reg0", 32'(rg(bus.regs_q, 0)), 32'h3);
        set_ctl(4'b0000, 1'b1, 3'd1, 3'd0, 3'd1, 2'b00);
        press(5'b10001);
        check("sim_load",   32'(rg(bus.regs_q, 0)), 32'h5);
        check("sim_res",    32'(bus.result_q), 32'h8);
        check("sim_flags",  32'(bus.flags_q),  32'h4);
        check("sim_strobe", 32'(bus.strobe_q), 32'h11);

        set_ctl(4'b0000, 1'b0, 3'd0, 3'd0, 3'd1, 2'b00);
        set_btn(5'b00100);
        repeat (50) @(negedge clk);
        check("held_once", 32'(rg(bus.regs_q, 2)), 32'h6);
        set_btn(5'b0);
        @(negedge clk);
        set_btn(5'b00100);
        repeat (4) @(negedge clk);
        check("regap_inc", 32'(rg(bus.regs_q, 2)), 32'h7);
        set_btn(5'b0);
        repeat (3) @(negedge clk);

        // Reset one edge into a press; the held button commits once after release
        set_btn(5'b00001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_regs",   32'(bus.regs_q),   32'h0);
        check("mid_rst_result", 32'(bus.result_q), 32'h0);
        check("mid_rst_flags",  32'(bus.flags_q),  32'h0);
        check("mid_rst_strobe", 32'(bus.strobe_q), 32'h0);
        repeat (3) @(negedge clk);
        check("rst_nocommit", 32'(bus.regs_q), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rel_commit", 32'(rg(bus.regs_q, 0)), 32'h1);
        check("rel_strobe", 32'(bus.strobe_q), 32'h01);
        repeat (10) @(negedge clk);
        check("rel_once", 32'(rg(bus.regs_q, 0)), 32'h1);
        set_btn(5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_reg_bank.md
# alu_reg_bank

Parametrised operand/result register bank with a registered ALU. It replaces fixed 4-bit A/B/num registers clocked directly from debounced button edges. NREG general registers of WIDTH bits each are stepped (increment/decrement, wrap or saturate) or loaded from a source mux on synchronously edge-detected button strobes. A separate commit strobe captures the ALU result and status flags into a result register. It sits between the `pbdebounce` instances and `disp_num`, and all state is in the single `clk` domain.

## Interface
Parameters:
- WIDTH, 4, bit width of every register and of the ALU (>=2)
- NREG, 4, number of general registers (>=2)
- SAT, 0, step mode: 0 = wrap-around, 1 = saturate at 0 / 2^WIDTH-1
- SELW, $clog2(NREG+1), width of the source/operand select fields

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn  in  NREG  debounced level per register; a rising edge commits that register
- dir  in  NREG  per register step direction: 0 = +1, 1 = -1
- load  in  1  0 = committed registers step; 1 = committed registers load src
- src_sel  in  SELW  load source: 0..NREG-1 = reg[i], NREG = result, other codes = 0
- a_sel, b_sel  in  SELW  ALU operand select, same decode as src_sel
- alu_op  in  2  00 ADD, 01 SUB (A-B), 10 AND, 11 XOR
- res_btn  in  1  debounced level; a rising edge commits the ALU output to the result register
- regs_q  out  NREG*WIDTH  reg[i] at bits [i*WIDTH +: WIDTH]
- result_q  out  WIDTH  result register
- alu_y  out  WIDTH  combinational ALU output for the current operands (preview)
- flags_q  out  3  {V, C, Z} captured at the last result commit
- strobe_q  out  NREG+1  one-cycle pulses, registered; bit NREG = result commit, for display/debug

## Operation
- Edge detection: each of btn[i] and res_btn passes through a 2-flop synchronizer s1->s2 plus a history flop s3. strobe = s2 & ~s3. There is no clocking from button signals.
- Register update on strobe[i]:
  - load=1: reg[i] <= src value.
  - load=0, dir=0: reg[i] <= reg[i]+1. Wraps max->0 when SAT=0; holds at max when SAT=1.
  - load=0, dir=1: reg[i] <= reg[i]-1. Wraps 0->max when SAT=0; holds at 0 when SAT=1.
- Result commit on strobe[NREG]: result_q <= alu_y and flags_q <= {V,C,Z}.
- ALU, computed at WIDTH+1 bits:
  - ADD: C = carry-out; V = signed overflow (operand signs equal, sum sign differs).
  - SUB: C = borrow (A<B unsigned); V = signed overflow (operand signs differ, result sign differs from A).
  - AND/XOR: C = 0, V = 0.
  - Z = (alu_y == 0) for all ops.
- Simultaneous strobes in one cycle: all commit on the same edge. Every load source, ALU operand and step base uses pre-edge register values; there is no intra-cycle forwarding. A register may load itself, which is a no-op.
- dir, load, src_sel, a_sel, b_sel and alu_op are sampled unsynchronized at the commit edge. The user holds them static around button presses.

## Timing
- Reset (rst_n=0, asynchronous): all regs, result_q, flags_q, strobe_q and all synchronizer/history flops go to 0.
- A button held high across reset release produces exactly one strobe, 2 edges after release.
- Latency: a btn rising edge that meets setup before clock edge k gives a register/result update at edge k+2. strobe_q pulses during the cycle after edge k+2.
- A held button gives exactly one commit. A new commit needs a low level for >=1 sampled cycle, then high again.
- Maximum rate is one commit per register per 2 cycles (high 1, low 1).
- alu_y and flags follow the operands combinationally. A commit captures the values present before the edge.
- Reset asserted mid-operation aborts any pending strobe. No commit occurs while rst_n=0.

## Test plan
- Reset/step: after reset, regs_q=0. WIDTH=4, SAT=0, dir[0]=1, pulse btn[0] -> reg0=F, 3 edges after the rise, strobe_q[0] one cycle. Pulse again -> E.
- Saturate: SAT=1, reg1=F, dir=0, pulse btn[1] -> stays F. reg1=0, dir=1 -> stays 0.
- ALU/flags: reg0=7, reg1=1, ADD, res_btn -> result_q=8, flags {V,C,Z}=100. SUB with reg0=1, reg1=2 -> result F, flags 010. XOR 5^5 -> 0, flags 001.
- Simultaneous: reg0=3, reg1=5, load=1, src_sel=1 on btn[0], and at the same time res_btn with ADD a=0 b=1 -> reg0=5, result_q=8 (pre-edge 3+5).
- Held/glitch: btn[2] held high 50 cycles -> exactly one increment. 1-cycle-low gap then high -> second increment.
- Reset mid-flight: assert rst_n low 1 edge after btn[0] rises -> all outputs 0, no commit. Btn still high at release -> single commit 2 edges later.
